// File: rtl/carrier_sequencer.sv
// Carrier sequencer: phase accumulator addressing a 32-entry sine table,
// registering the returned sample as a valid-qualified stream in bursts or continuously.
module carrier_sequencer #(
  parameter int unsigned PHASE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic [7:0]         cfg_periods,
  input  logic               start,
  input  logic               stop,
  output logic [4:0]         lut_addr,
  input  logic [7:0]         lut_data,
  output logic [7:0]         sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [DATA_W-1:0] SAMPLE_RST = DATA_W'(127);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [CNT_W-1:0]   periods_q, periods_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic [PHASE_W:0]   sum_c;
  logic               wrap_c;
  logic               cfg_xfer_c;
  logic [PHASE_W-1:0] eff_fcw_c;
  logic [CNT_W-1:0]   eff_per_c;
  logic               counted_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fcw_q       <= '0;
      periods_q   <= '0;
      acc_q       <= '0;
      per_cnt_q   <= '0;
      sample_q    <= SAMPLE_RST;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      fcw_q       <= fcw_d;
      periods_q   <= periods_d;
      acc_q       <= acc_d;
      per_cnt_q   <= per_cnt_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  // Next-state, accumulator stepping and sample capture
  always_comb begin
    state_d     = state_q;
    fcw_d       = fcw_q;
    periods_d   = periods_q;
    acc_d       = acc_q;
    per_cnt_d   = per_cnt_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;

    sum_c      = {1'b0, acc_q} + {1'b0, fcw_q};
    wrap_c     = sum_c[PHASE_W];
    cfg_xfer_c = cfg_valid && cfg_ready_q;
    eff_fcw_c  = cfg_xfer_c ? cfg_fcw : fcw_q;
    eff_per_c  = cfg_xfer_c ? cfg_periods : periods_q;
    counted_c  = wrap_c && (periods_q != '0);

    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (cfg_xfer_c) begin
          fcw_d     = cfg_fcw;
          periods_d = cfg_periods;
        end
        if (start && !stop && (eff_fcw_c != '0)) begin
          state_d   = RUN;
          per_cnt_d = eff_per_c;
        end
      end
      RUN: begin
        acc_d = sum_c[PHASE_W-1:0];
        if (counted_c && (per_cnt_q == CNT_W'(1))) begin
          state_d = IDLE;
          acc_d   = '0;
          done_d  = 1'b1;
        end else begin
          if (counted_c) per_cnt_d = per_cnt_q - CNT_W'(1);
          if (stop) state_d = STOP;
        end
      end
      STOP: begin
        acc_d = sum_c[PHASE_W-1:0];
        if (wrap_c) begin
          state_d = IDLE;
          acc_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase

    if (state_q != IDLE) begin
      sample_d = lut_data;
      valid_d  = 1'b1;
    end

    busy_d      = (state_d != IDLE);
    cfg_ready_d = (state_d == IDLE);
  end

  assign lut_addr     = acc_q[PHASE_W-1 -: ADDR_W];
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign cfg_ready    = cfg_ready_q;

endmodule

// File: tb/tb_carrier_sequencer.sv
// Bench for carrier_sequencer: sine table stand-in, arithmetic run model and per-cycle compare.
module tb_carrier_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_fcw;
  logic [7:0]  cfg_periods;
  logic        start;
  logic        stop;
  logic [4:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;

  carrier_sequencer #(.PHASE_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_fcw      (cfg_fcw),
    .cfg_periods  (cfg_periods),
    .start        (start),
    .stop         (stop),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  // floor(127.5 + 127.5*sin(2*pi*k/32))
  logic [7:0] sine_rom [32] = '{
    8'd127, 8'd152, 8'd176, 8'd198, 8'd217, 8'd233, 8'd245, 8'd252,
    8'd255, 8'd252, 8'd245, 8'd233, 8'd217, 8'd198, 8'd176, 8'd152,
    8'd127, 8'd102, 8'd78,  8'd56,  8'd37,  8'd21,  8'd9,   8'd2,
    8'd0,   8'd2,   8'd9,   8'd21,  8'd37,  8'd56,  8'd78,  8'd102
  };
  assign lut_data = sine_rom[lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;
  always @(posedge clk) e++;

  // model state
  int          m_fcw = 0;
  int          m_per = 0;
  bit          run_on = 0;
  int          e0 = 0;
  int          n_steps = 0;
  int          exp_addr[$];
  int          last_sample = 127;
  bit          chk_en = 0;

  int          samp_q[$];
  int          done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Number of stepping cycles: ends on the p-th wrap, or the first wrap after a stop.
  function automatic int model_len(input int f, input int p, input int s);
    int wraps = 0;
    for (int j = 1; j < 5000; j++) begin
      longint hi_now, hi_prev;
      hi_now  = (longint'(j) * f) >> 16;
      hi_prev = (longint'(j - 1) * f) >> 16;
      if (hi_now > hi_prev) begin
        wraps++;
        if ((p != 0 && wraps == p) || (s > 0 && j > s)) return j;
      end
    end
    return 5000;
  endfunction

  always @(negedge clk) begin
    if (sample_valid) samp_q.push_back(int'(sample_out));
    if (done) done_cnt++;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    int rel, ad, so;
    bit bz, sv, dn;
    if (chk_en) begin
      rel = e - e0;
      bz = 0; sv = 0; dn = 0; ad = 0; so = last_sample;
      if (run_on) begin
        if (rel >= 0 && rel < n_steps) begin bz = 1; ad = exp_addr[rel]; end
        if (rel >= 1 && rel <= n_steps) begin sv = 1; so = int'(sine_rom[exp_addr[rel-1]]); end
        if (rel == n_steps) dn = 1;
      end
      chk("busy", int'(busy), int'(bz));
      chk("cfg_ready", int'(cfg_ready), int'(!bz));
      chk("lut_addr", int'(lut_addr), ad);
      chk("sample_valid", int'(sample_valid), int'(sv));
      chk("sample_out", int'(sample_out), so);
      chk("done", int'(done), int'(dn));
      if (sv) last_sample = so;
      if (run_on && rel >= n_steps) run_on = 0;
    end
  end

  task automatic do_cfg(input int f, input int p);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_fcw = 16'(f); cfg_periods = 8'(p);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_fcw = f; m_per = p;
  endtask

  task automatic launch(input bit with_cfg, input int f, input int p, input int stop_at);
    @(negedge clk);
    if (with_cfg) begin
      cfg_valid = 1'b1; cfg_fcw = 16'(f); cfg_periods = 8'(p);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_valid = 1'b0;
    if (with_cfg) begin m_fcw = f; m_per = p; end
    if (m_fcw != 0) begin
      e0 = e;
      n_steps = model_len(m_fcw, m_per, stop_at);
      exp_addr.delete();
      for (int k = 0; k < n_steps; k++)
        exp_addr.push_back(int'(((longint'(k) * m_fcw) % 65536) >> 11));
      run_on = 1;
      if (stop_at > 0) begin
        repeat (stop_at - 1) @(posedge clk);
        @(negedge clk); stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
      end
    end
  endtask

  task automatic wait_end();
    while (run_on || e < e0 + n_steps + 2) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    samp_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_fcw = '0; cfg_periods = '0;
    start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_sample_out", int'(sample_out), 127);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_lut_addr", int'(lut_addr), 0);
    @(negedge clk); reset_n = 1'b1; chk_en = 1;
    @(negedge clk);
    chk("rst_cfg_ready", int'(cfg_ready), 1);

    // two-period burst
    clear_mon();
    do_cfg(16'h0800, 2);
    launch(0, 0, 0, 0);
    wait_end();
    chk("a_count", samp_q.size(), 64);
    chk("a_done_cnt", done_cnt, 1);
    if (samp_q.size() == 64) begin
      chk("a_s0", samp_q[0], 127);
      chk("a_s1", samp_q[1], 152);
      chk("a_s2", samp_q[2], 176);
      chk("a_s8", samp_q[8], 255);
      chk("a_s24", samp_q[24], 0);
      chk("a_s32", samp_q[32], 127);
      chk("a_s63", samp_q[63], 102);
    end

    // continuous, stop on 40th stepping cycle
    clear_mon();
    do_cfg(16'h1000, 0);
    launch(0, 0, 0, 40);
    wait_end();
    chk("b_count", samp_q.size(), 48);
    chk("b_done_cnt", done_cnt, 1);
    if (samp_q.size() == 48) begin
      chk("b_s1", samp_q[1], 176);
      chk("b_s47", samp_q[47], 78);
    end

    // stop coincident with terminating wrap
    clear_mon();
    launch(1, 16'h0800, 1, 32);
    wait_end();
    chk("c_count", samp_q.size(), 32);
    chk("c_done_cnt", done_cnt, 1);

    // zero fcw start ignored, then cfg+start same cycle
    clear_mon();
    do_cfg(0, 1);
    launch(0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("d_zero_count", samp_q.size(), 0);
    launch(1, 16'h0800, 1, 0);
    wait_end();
    chk("d_count", samp_q.size(), 32);
    chk("d_done_cnt", done_cnt, 1);

    // cfg and start during a run are refused
    clear_mon();
    launch(1, 16'h1000, 1, 0);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_fcw = 16'h0400; cfg_periods = 8'd5; start = 1'b1;
    chk("e_cfg_ready_run", int'(cfg_ready), 0);
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b0;
    wait_end();
    chk("e_count", samp_q.size(), 16);
    clear_mon();
    launch(0, 0, 0, 0);
    wait_end();
    chk("e_reuse_count", samp_q.size(), 16);

    // start and stop together in IDLE
    clear_mon();
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("f_count", samp_q.size(), 0);
    chk("f_busy", int'(busy), 0);

    // reset mid-run
    clear_mon();
    launch(1, 16'h0800, 2, 0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    run_on = 0; last_sample = 127; m_fcw = 0; m_per = 0;
    chk("g_busy", int'(busy), 0);
    chk("g_valid", int'(sample_valid), 0);
    chk("g_done", int'(done), 0);
    chk("g_sample_out", int'(sample_out), 127);
    chk("g_lut_addr", int'(lut_addr), 0);
    @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("g_cfg_ready", int'(cfg_ready), 1);
    launch(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("g_no_run_after_rst", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
